div_batch_mem_ctrl: RTL and testbench

Parametrised scratch-memory sequencer for the histogram-equalisation divider array. It reads CDF value pairs from scratch memory and presents them to `NUM_DIV` divider lanes. It waits for every enabled lane to finish, then writes both quotients back to the output region. Unlike the previous fixed-size controller, it adds:
- configurable base addresses, entry count and read latency
- a per-lane enable mask
- a start/busy/done handshake
- a synchronous abort
- a divider timeout with an error flag

---
 rtl/div_batch_mem_ctrl.sv | 116 +++++++++++
 tb/tb_div_batch_mem_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_batch_mem_ctrl.sv
// div_batch_mem_ctrl: sequences CDF pair reads, divider lanes and quotient write-back
module div_batch_mem_ctrl #(
   parameter int ADDR_W      = 16,
   parameter int NUM_DIV     = 8,
   parameter int RD_BASE     = 64,
   parameter int WT_BASE     = 128,
   parameter int NUM_ENTRIES = 64,
   parameter int RD_LAT      = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [NUM_DIV-1:0] lane_mask,
   input  logic [NUM_DIV-1:0] div_done,
   output logic [ADDR_W-1:0]  sc_mem_rd_addr1,
   output logic [ADDR_W-1:0]  sc_mem_rd_addr2,
   output logic               sc_mem_rd_en,
   output logic               sc_mem_rd_data_rdy,
   output logic               div_en,
   output logic [ADDR_W-1:0]  sc_mem_wt_addr,
   output logic               sc_mem_wt_en,
   output logic               wt_sel,
   output logic               busy,
   output logic               done,
   output logic               err
);
   localparam int K_W = (NUM_ENTRIES / 2 > 1) ? $clog2(NUM_ENTRIES / 2) : 1;
   localparam int L_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int T_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [K_W-1:0]    K_LAST = K_W'(NUM_ENTRIES / 2 - 1);
   localparam logic [L_W-1:0]    L_LAST = L_W'(RD_LAT - 1);
   localparam logic [T_W-1:0]    T_MAX  = T_W'(TIMEOUT);
   localparam logic [ADDR_W-1:0] RD_B   = ADDR_W'(RD_BASE);
   localparam logic [ADDR_W-1:0] WT_B   = ADDR_W'(WT_BASE);

   typedef enum logic [3:0] {
      IDLE, ISSUE_RD, RD_WAIT, RD_RDY, DIV_START, DIV_WAIT, WR0, WR1, COMPLETE
   } state_t;

   state_t             state_q, state_nxt;
   logic [K_W-1:0]     k_q, k_n;
   logic [L_W-1:0]     lat_q;
   logic [T_W-1:0]     tmo_q;
   logic [NUM_DIV-1:0] mask_q;
   logic               all_done;

   assign all_done = &(div_done | ~mask_q);
   assign k_n      = (state_q == IDLE) ? '0 : k_q + 1'b1;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else state_q <= state_nxt;
   end

   // next state: start only matters in IDLE, abort overrides everything elsewhere
   always_comb begin
      state_nxt = state_q;
      if (state_q == IDLE) state_nxt = start ? ISSUE_RD : IDLE;
      else if (abort) state_nxt = IDLE;
      else begin
         case (state_q)
            ISSUE_RD:  state_nxt = RD_WAIT;
            RD_WAIT:   state_nxt = (lat_q == L_LAST) ? RD_RDY : RD_WAIT;
            RD_RDY:    state_nxt = DIV_START;
            DIV_START: state_nxt = DIV_WAIT;
            DIV_WAIT:  state_nxt = all_done ? WR0 : (tmo_q == T_MAX) ? COMPLETE : DIV_WAIT;
            WR0:       state_nxt = WR1;
            WR1:       state_nxt = (k_q == K_LAST) ? COMPLETE : ISSUE_RD;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // Moore strobes decoded from the state register
   always_comb begin
      sc_mem_rd_en       = state_q == ISSUE_RD;
      sc_mem_rd_data_rdy = state_q == RD_RDY;
      div_en             = state_q == DIV_START;
      sc_mem_wt_en       = state_q == WR0 || state_q == WR1;
      wt_sel             = state_q == WR1;
      busy               = state_q != IDLE;
      done               = state_q == COMPLETE;
   end

   // batch index, wait counters, latched mask, sticky error and address registers
   always_ff @(posedge clk) begin
      if (reset) begin
         k_q             <= '0;
         lat_q           <= '0;
         tmo_q           <= '0;
         mask_q          <= '0;
         err             <= 1'b0;
         sc_mem_rd_addr1 <= '0;
         sc_mem_rd_addr2 <= '0;
         sc_mem_wt_addr  <= '0;
      end else begin
         lat_q <= (state_q == RD_WAIT) ? lat_q + 1'b1 : '0;
         tmo_q <= (state_q == DIV_WAIT) ? tmo_q + 1'b1 : '0;
         if (state_q == IDLE && start) begin
            mask_q <= lane_mask;
            err    <= 1'b0;
         end
         if (state_q == DIV_WAIT && state_nxt == COMPLETE) err <= 1'b1;
         if (state_nxt == ISSUE_RD) begin
            k_q             <= k_n;
            sc_mem_rd_addr1 <= RD_B + ADDR_W'({k_n, 1'b0});
            sc_mem_rd_addr2 <= RD_B + ADDR_W'({k_n, 1'b1});
         end
         if (state_nxt == WR0 || state_nxt == WR1)
            sc_mem_wt_addr <= WT_B + ADDR_W'({k_q, state_nxt == WR1});
      end
   end
endmodule

// File: tb/tb_div_batch_mem_ctrl.sv
// tb_div_batch_mem_ctrl: schedule-based reference check of the batch sequencer
module tb_div_batch_mem_ctrl;
   localparam int MAXC = 2048;

   typedef struct packed {
      logic [15:0] ra1, ra2, wa;
      logic        rd_en, rdy, den, wen, wsel, busy, done, err;
   } out_t;

   logic clk = 1'b0;
   logic reset, st_a, st_b, abort;
   logic [7:0] lane_mask, div_done;

   logic [15:0] ra1_a, ra2_a, wa_a, ra1_b, ra2_b, wa_b;
   logic rd_en_a, rdy_a, den_a, wen_a, wsel_a, busy_a, done_a, err_a;
   logic rd_en_b, rdy_b, den_b, wen_b, wsel_b, busy_b, done_b, err_b;
   out_t o_a, o_b;

   out_t       exp_o [MAXC];
   logic [7:0] dd [MAXC];
   logic       ab [MAXC];
   logic       sv [MAXC];
   out_t       hold [2];

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int first_den, done_cyc, n_done, n_rd, n_wr;

   always #5 clk = ~clk;

   div_batch_mem_ctrl u_dut_a (
      .clk(clk), .reset(reset), .start(st_a), .abort(abort),
      .lane_mask(lane_mask), .div_done(div_done),
      .sc_mem_rd_addr1(ra1_a), .sc_mem_rd_addr2(ra2_a), .sc_mem_rd_en(rd_en_a),
      .sc_mem_rd_data_rdy(rdy_a), .div_en(den_a), .sc_mem_wt_addr(wa_a),
      .sc_mem_wt_en(wen_a), .wt_sel(wsel_a), .busy(busy_a), .done(done_a), .err(err_a)
   );

   div_batch_mem_ctrl #(.NUM_ENTRIES(2), .RD_LAT(1), .RD_BASE(16'hFFFF), .TIMEOUT(15)) u_dut_b (
      .clk(clk), .reset(reset), .start(st_b), .abort(abort),
      .lane_mask(lane_mask), .div_done(div_done),
      .sc_mem_rd_addr1(ra1_b), .sc_mem_rd_addr2(ra2_b), .sc_mem_rd_en(rd_en_b),
      .sc_mem_rd_data_rdy(rdy_b), .div_en(den_b), .sc_mem_wt_addr(wa_b),
      .sc_mem_wt_en(wen_b), .wt_sel(wsel_b), .busy(busy_b), .done(done_b), .err(err_b)
   );

   assign o_a = {ra1_a, ra2_a, wa_a, rd_en_a, rdy_a, den_a, wen_a, wsel_a, busy_a, done_a, err_a};
   assign o_b = {ra1_b, ra2_b, wa_b, rd_en_b, rdy_b, den_b, wen_b, wsel_b, busy_b, done_b, err_b};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
      end
   endtask

   // Builds the expected per-cycle trace from batch arithmetic, then drives and checks it.
   // sel picks the instance, wmode<0 gives random done delays, to_batch times out on lane 2.
   task automatic run(input bit sel, input logic [7:0] mask, input logic [7:0] stuck,
                      input int wmode, input int to_batch, input int ab_cyc, input bit ab_at_start);
      int lat, nb, tmo, b, dw, w, fin, last, ln;
      logic [15:0] rb;
      out_t cur;
      lat = sel ? 1 : 2;
      nb  = sel ? 1 : 32;
      tmo = sel ? 15 : 1023;
      rb  = sel ? 16'hFFFF : 16'd64;
      fin = -1;
      b   = 1;
      for (int c = 0; c < MAXC; c++) begin
         exp_o[c]     = '0;
         exp_o[c].ra1 = hold[sel].ra1;
         exp_o[c].ra2 = hold[sel].ra2;
         dd[c]        = 8'($urandom);
         ab[c]        = 1'b0;
         sv[c]        = 1'b0;
      end
      exp_o[0].err = hold[sel].err;
      for (int k = 0; k < nb && fin < 0; k++) begin
         for (int c = b; c < MAXC; c++) begin
            exp_o[c].ra1 = rb + 16'(2 * k);
            exp_o[c].ra2 = rb + 16'(2 * k + 1);
         end
         exp_o[b].rd_en           = 1'b1;
         exp_o[b + lat + 1].rdy   = 1'b1;
         exp_o[b + lat + 2].den   = 1'b1;
         dd[b + lat + 2]          = 8'hFF;
         dw = b + lat + 3;
         if (k == to_batch) begin
            for (int c = dw; c <= dw + tmo; c++) dd[c][2] = 1'b0;
            fin = dw + tmo + 1;
            for (int c = fin; c < MAXC; c++) exp_o[c].err = 1'b1;
         end else begin
            w = (mask == 8'h00) ? 0 : (wmode < 0) ? int'($urandom_range(4, 0)) : wmode;
            for (int c = dw; c < dw + w; c++) begin
               do ln = int'($urandom_range(7, 0)); while (!mask[ln]);
               dd[c][ln] = 1'b0;
            end
            dd[dw + w] = dd[dw + w] | mask;
            exp_o[dw + w + 1].wen  = 1'b1;
            exp_o[dw + w + 1].wa   = 16'd128 + 16'(2 * k);
            exp_o[dw + w + 2].wen  = 1'b1;
            exp_o[dw + w + 2].wa   = 16'd129 + 16'(2 * k);
            exp_o[dw + w + 2].wsel = 1'b1;
            b = dw + w + 3;
         end
      end
      if (fin < 0) fin = b;
      exp_o[fin].done = 1'b1;
      for (int c = 1; c <= fin; c++) exp_o[c].busy = 1'b1;
      last = fin;
      if (ab_cyc > 0) begin
         last = ab_cyc;
         ab[ab_cyc] = 1'b1;
         for (int c = ab_cyc + 1; c < MAXC; c++) begin
            exp_o[c]     = '0;
            exp_o[c].ra1 = exp_o[ab_cyc].ra1;
            exp_o[c].ra2 = exp_o[ab_cyc].ra2;
            exp_o[c].err = exp_o[ab_cyc].err;
         end
      end
      for (int c = 0; c < MAXC; c++) dd[c] = dd[c] & ~stuck;
      sv[0] = 1'b1;
      for (int c = 1; c <= last; c++) sv[c] = 1'($urandom_range(1, 0));
      ab[0]        = ab_at_start;
      ab[last + 1] = 1'b1;
      first_den = -1; done_cyc = -1; n_done = 0; n_rd = 0; n_wr = 0;
      for (int c = 0; c <= last + 2; c++) begin
         @(negedge clk);
         cur = sel ? o_b : o_a;
         chk($sformatf("strobes@%0d", c),
             64'({cur.rd_en, cur.rdy, cur.den, cur.wen, cur.busy, cur.done, cur.err}),
             64'({exp_o[c].rd_en, exp_o[c].rdy, exp_o[c].den, exp_o[c].wen,
                  exp_o[c].busy, exp_o[c].done, exp_o[c].err}));
         chk($sformatf("rd_addr1@%0d", c), 64'(cur.ra1), 64'(exp_o[c].ra1));
         chk($sformatf("rd_addr2@%0d", c), 64'(cur.ra2), 64'(exp_o[c].ra2));
         if (exp_o[c].wen) begin
            chk($sformatf("wt_addr@%0d", c), 64'(cur.wa), 64'(exp_o[c].wa));
            chk($sformatf("wt_sel@%0d", c), 64'(cur.wsel), 64'(exp_o[c].wsel));
         end
         if (cur.den && first_den < 0) first_den = c;
         if (cur.done) begin
            done_cyc = c;
            n_done++;
         end
         n_rd += int'(cur.rd_en);
         n_wr += int'(cur.wen);
         st_a      = !sel && sv[c];
         st_b      = sel && sv[c];
         abort     = ab[c];
         div_done  = dd[c];
         lane_mask = (c == 0) ? mask : 8'($urandom);
      end
      hold[sel] = exp_o[last + 2];
   endtask

   initial begin
      reset = 1'b1; st_a = 1'b0; st_b = 1'b0; abort = 1'b0;
      lane_mask = '0; div_done = '0;
      hold[0] = '0; hold[1] = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_a", 64'(o_a), 64'(0));
      chk("reset_b", 64'(o_b), 64'(0));
      // nominal: done 3 cycles after each div_en
      run(1'b0, 8'hFF, 8'h00, 2, -1, 0, 1'b0);
      chk("nom_first_div_en", 64'(first_den), 64'(5));
      chk("nom_reads", 64'(n_rd), 64'(32));
      chk("nom_writes", 64'(n_wr), 64'(64));
      chk("nom_done_pulses", 64'(n_done), 64'(1));
      chk("nom_done_cycle", 64'(done_cyc), 64'(321));
      // upper lanes masked off and never done
      run(1'b0, 8'h0F, 8'hF0, -1, -1, 0, 1'b0);
      chk("mask0f_done_pulses", 64'(n_done), 64'(1));
      chk("mask0f_writes", 64'(n_wr), 64'(64));
      // empty mask: 8-cycle batches
      run(1'b0, 8'h00, 8'hFF, 0, -1, 0, 1'b0);
      chk("mask00_done_cycle", 64'(done_cyc), 64'(257));
      // timeout in batch 3
      run(1'b0, 8'hFF, 8'h00, 1, 3, 0, 1'b0);
      chk("to_done_cycle", 64'(done_cyc), 64'(1057));
      chk("to_writes", 64'(n_wr), 64'(6));
      // err clears on start; start beats simultaneous abort
      run(1'b0, 8'($urandom) | 8'h01, 8'h00, -1, -1, 0, 1'b1);
      chk("restart_done_pulses", 64'(n_done), 64'(1));
      // abort in DIV_WAIT of batch 5
      run(1'b0, 8'hFF, 8'h00, 3, -1, 62, 1'b0);
      chk("abort_done_pulses", 64'(n_done), 64'(0));
      chk("abort_writes", 64'(n_wr), 64'(10));
      run(1'b0, 8'($urandom), 8'h00, -1, -1, 0, 1'b0);
      chk("after_abort_done_pulses", 64'(n_done), 64'(1));
      // reset in the middle of a run
      st_a = 1'b1; lane_mask = 8'hFF;
      @(negedge clk);
      st_a = 1'b0;
      repeat (20) begin
         div_done = 8'($urandom);
         @(negedge clk);
      end
      chk("busy_before_reset", 64'(o_a.busy), 64'(1));
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_a", 64'(o_a), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("postreset_a", 64'(o_a), 64'(0));
      chk("postreset_b", 64'(o_b), 64'(0));
      hold[0] = '0; hold[1] = '0;
      run(1'b0, 8'hFF, 8'h00, 2, -1, 0, 1'b0);
      chk("postreset_done_cycle", 64'(done_cyc), 64'(321));
      // small instance: one batch, wrapping read address
      run(1'b1, 8'hFF, 8'h00, 0, -1, 0, 1'b0);
      chk("small_done_cycle", 64'(done_cyc), 64'(8));
      chk("small_writes", 64'(n_wr), 64'(2));
      run(1'b1, 8'hFF, 8'h00, 0, 0, 0, 1'b0);
      chk("small_to_done_cycle", 64'(done_cyc), 64'(21));
      repeat (3) run(1'b1, 8'($urandom), 8'h00, -1, -1, 0, 1'($urandom_range(1, 0)));
      repeat (2) run(1'b0, 8'($urandom), 8'h00, -1, -1, 0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
